// File: rtl/cnn_l1_pkg.sv
// -----------------------------------------------------------------------------
// cnn_l1_pkg
// Shared definitions for the layer-1 conv/ReLU/max-pool datapath of the 1-D
// CNN ECG classifier. The package contains:
//   - the layer geometry,
//   - the sample, window and channel-vector types,
//   - the fixed kernel coefficients W (Q1.6) and biases B (output LSBs),
//   - helpers for sign extension and saturation to int8.
// Trained coefficients replace W/B later and keep the same format.
// -----------------------------------------------------------------------------
package cnn_l1_pkg;

    localparam int DATA_W = 8;   // sample / weight / output width
    localparam int KERNEL = 5;   // taps per kernel
    localparam int N_CH   = 4;   // output channels
    localparam int POOL   = 5;   // conv results per pooled output
    localparam int FRAC   = 6;   // fractional bits of the weights (64 = 1.0)

    // The full 8x8 product plus growth for KERNEL terms, and one spare bit
    // so that adding the bias can never wrap.
    localparam int ACC_W  = 2 * DATA_W + $clog2(KERNEL) + 1;
    localparam int CNT_W  = $clog2(POOL);

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef sample_t [KERNEL-1:0]     window_t;   // [0] = oldest sample
    typedef sample_t [N_CH-1:0]       chvec_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam sample_t W [N_CH][KERNEL] = '{
        '{ 8'sd64,  8'sd0,  8'sd0,  8'sd0,  8'sd0},  // identity of oldest
        '{-8'sd64,  8'sd0,  8'sd0,  8'sd0,  8'sd0},  // negated oldest
        '{ 8'sd16,  8'sd16, 8'sd16, 8'sd16, 8'sd16}, // sum / 4
        '{ 8'sd0,   8'sd0,  8'sd64, 8'sd0,  8'sd0}   // centre sample
    };

    localparam sample_t B [N_CH] = '{8'sd0, 8'sd0, 8'sd0, -8'sd1};

    function automatic acc_t sext(input sample_t x);
        return acc_t'(x);
    endfunction

    function automatic sample_t sat8(input acc_t v);
        if (v > acc_t'(127)) begin
            return sample_t'(127);
        end else if (v < acc_t'(-128)) begin
            return sample_t'(-128);
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/conv_relu_pool_layer1_mac.sv
// -----------------------------------------------------------------------------
// conv_mac_ch
// One channel of the layer-1 convolution. This block is purely
// combinational; the parent module registers its output. It computes a
// 5-tap signed MAC against the channel's kernel. The sum is floored by an
// arithmetic shift of FRAC bits, the integer bias is added, and the result
// is saturated to int8.
// Parameters:
//   CH     channel index that selects W[CH] / B[CH]
// Ports:
//   i_win  input window, element 0 = oldest sample
//   o_y    saturated pre-activation result for this channel
// -----------------------------------------------------------------------------
module conv_mac_ch
    import cnn_l1_pkg::*;
#(
    parameter int CH = 0
) (
    input  window_t i_win,
    output sample_t o_y
);

    acc_t w_acc;
    acc_t w_biased;

    // NOTE: every signal written in always_comb is given a value before the
    // loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < KERNEL; k++) begin
            w_acc = w_acc + sext(i_win[k]) * sext(W[CH][k]);
        end
    end

    // >>> on a signed operand rounds toward minus infinity (floor).
    assign w_biased = (w_acc >>> FRAC) + sext(B[CH]);
    assign o_y      = sat8(w_biased);

endmodule

// File: rtl/conv_relu_pool_layer1.sv
// -----------------------------------------------------------------------------
// conv_relu_pool_layer1
// Streaming first layer of the ECG CNN, organised as three stages:
//   - Convolution: each accepted window is convolved with N_CH fixed kernels,
//     and the results are registered one cycle later.
//   - ReLU: applied combinationally to the conv registers.
//   - Max-pool: each channel takes the maximum over POOL consecutive conv
//     results, with stride POOL.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clr        synchronous group restart; a window in the same cycle becomes
//              the first window of the new group
//   in_valid   a window is present this cycle
//   in_win     KERNEL signed samples, element 0 = oldest
//   out_ch     pooled ReLU outputs (0..127), held between pulses
//   out_valid  one-cycle pulse marking a new out_ch
// -----------------------------------------------------------------------------
module conv_relu_pool_layer1
    import cnn_l1_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    in_valid,
    input  window_t in_win,
    output chvec_t  out_ch,
    output logic    out_valid
);

    sample_t          w_conv_next [N_CH];
    sample_t          w_relu      [N_CH];
    sample_t          w_merge     [N_CH];
    logic             w_last;

    sample_t          r_conv      [N_CH];
    logic             r_conv_valid;
    sample_t          r_max       [N_CH];
    logic [CNT_W-1:0] r_count;
    chvec_t           r_out;
    logic             r_out_valid;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        conv_mac_ch #(.CH(c)) u_mac (
            .i_win (in_win),
            .o_y   (w_conv_next[c])
        );
    end

    // w_merge is the running max after the current conv result has been
    // folded in. The first result of a group replaces the stale maximum, so
    // the maximum from one group never leaks into the next.
    always_comb begin
        w_last = (r_count == CNT_W'(POOL - 1));
        for (int c = 0; c < N_CH; c++) begin
            w_relu[c]  = r_conv[c][DATA_W-1] ? '0 : r_conv[c];
            w_merge[c] = ((r_count == '0) || (w_relu[c] > r_max[c]))
                         ? w_relu[c] : r_max[c];
        end
    end

    // NOTE: all state here, including the small per-channel arrays, is made
    // of flops and is cleared on reset, so a group aborted by rst cannot
    // produce a partial output.
    // NOTE: sequential state is updated only with non-blocking assignments,
    // so every read in this block sees the value from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conv_valid <= 1'b0;
            r_count      <= '0;
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_conv[c] <= '0;
                r_max[c]  <= '0;
            end
        end else begin
            r_out_valid  <= 1'b0;
            r_conv_valid <= in_valid;
            if (in_valid) begin
                for (int c = 0; c < N_CH; c++) begin
                    r_conv[c] <= w_conv_next[c];
                end
            end

            if (clr) begin
                // The conv result registered before this edge is dropped,
                // because it is not folded into the pool.
                r_count <= '0;
                for (int c = 0; c < N_CH; c++) begin
                    r_max[c] <= '0;
                end
            end else if (r_conv_valid) begin
                if (w_last) begin
                    r_count     <= '0;
                    r_out_valid <= 1'b1;
                    for (int c = 0; c < N_CH; c++) begin
                        r_out[c] <= w_merge[c];
                    end
                end else begin
                    r_count <= r_count + CNT_W'(1);
                    for (int c = 0; c < N_CH; c++) begin
                        r_max[c] <= w_merge[c];
                    end
                end
            end
        end
    end

    assign out_ch    = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_conv_relu_pool_layer1.sv
// -----------------------------------------------------------------------------
// tb_conv_relu_pool_layer1
// Self-checking bench for conv_relu_pool_layer1.
// The directed scenarios compare against hand-derived constants. A randomized
// phase compares every cycle against a reference model. The model computes
// each conv result with plain integer arithmetic and keeps the current pool
// group as a queue of results.
// -----------------------------------------------------------------------------
module tb_conv_relu_pool_layer1;
    import cnn_l1_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    clr;
    logic    in_valid;
    window_t in_win;
    chvec_t  out_ch;
    logic    out_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_relu_pool_layer1 dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_win    (in_win),
        .out_ch    (out_ch),
        .out_valid (out_valid)
    );

    // ---------------- reference model ----------------
    localparam int REF_W [4][5] = '{
        '{ 64,  0,  0,  0,  0},
        '{-64,  0,  0,  0,  0},
        '{ 16, 16, 16, 16, 16},
        '{  0,  0, 64,  0,  0}
    };
    localparam int REF_B [4] = '{0, 0, 0, -1};

    typedef struct { int v [4]; } res_t;

    res_t grp [$];      // ReLU results of the current pool group
    bit   pend_v;       // a conv result is waiting to enter the pool
    res_t pend;
    bit   exp_valid;
    int   exp_out [4];

    function automatic int ref_relu_conv(int c, window_t w);
        int acc = 0;
        int y;
        for (int k = 0; k < 5; k++) begin
            acc += REF_W[c][k] * int'($signed(w[k]));
        end
        y = acc / 64;
        if (acc < 0 && (acc % 64) != 0) y = y - 1;  // floor division
        y = y + REF_B[c];
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return (y < 0) ? 0 : y;
    endfunction

    function automatic void model_reset();
        grp.delete();
        pend_v    = 1'b0;
        exp_valid = 1'b0;
        for (int c = 0; c < 4; c++) exp_out[c] = 0;
    endfunction

    function automatic void model_edge(bit v, window_t w, bit c_clr);
        exp_valid = 1'b0;
        if (c_clr) begin
            grp.delete();
        end else if (pend_v) begin
            grp.push_back(pend);
            if (grp.size() == 5) begin
                for (int c = 0; c < 4; c++) begin
                    int m = 0;
                    foreach (grp[i]) if (grp[i].v[c] > m) m = grp[i].v[c];
                    exp_out[c] = m;
                end
                exp_valid = 1'b1;
                grp.delete();
            end
        end
        pend_v = v;
        if (v) for (int c = 0; c < 4; c++) pend.v[c] = ref_relu_conv(c, w);
    endfunction

    function automatic window_t mk_win(int oldest, int rest);
        window_t w;
        for (int k = 0; k < 5; k++) w[k] = sample_t'((k == 0) ? oldest : rest);
        return w;
    endfunction

    function automatic window_t rand_win();
        window_t w;
        for (int k = 0; k < 5; k++) begin
            case ($urandom_range(0, 5))
                0:       w[k] = sample_t'(127);
                1:       w[k] = sample_t'(-128);
                default: w[k] = sample_t'($urandom_range(0, 255));
            endcase
        end
        return w;
    endfunction

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input bit v, input window_t w, input bit c_clr);
        @(negedge clk);
        in_valid = v;
        in_win   = w;
        clr      = c_clr;
        @(posedge clk);
        #1;
        model_edge(v, w, c_clr);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; in_valid = 1'b1; in_win = mk_win(127, 127);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_ch !== '0) begin
            errors++; $display("FAIL reset_out: got %h expected 0", out_ch);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int seq [5] = '{10, -20, 30, 127, 5};
        int exp [4] = '{127, 20, 31, 0};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, mk_win(seq[i], 0), 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL basic_early_valid: step %0d got %b expected 0", i, out_valid);
            end
        end
        step(1'b0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL basic_pulse: got %b expected 1", out_valid);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_ch[c] !== sample_t'(exp[c])) begin
                errors++; $display("FAIL basic_ch%0d: got %0d expected %0d", c, $signed(out_ch[c]), exp[c]);
            end
        end
        step(1'b0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_ch[0] !== sample_t'(127)) begin
            errors++; $display("FAIL basic_hold: valid %b ch0 %0d expected 0 / 127", out_valid, $signed(out_ch[0]));
        end
    endtask

    task automatic test_saturation();
        int exp_hi [4] = '{127, 0, 127, 126};
        int exp_lo [4] = '{0, 127, 0, 0};
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 5; i++) step(1'b1, mk_win(g ? -128 : 127, g ? -128 : 127), 1'b0);
            step(1'b0, '0, 1'b0);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL sat_pulse%0d: got %b expected 1", g, out_valid);
            end
            for (int c = 0; c < 4; c++) begin
                int e = g ? exp_lo[c] : exp_hi[c];
                checks++;
                if (out_ch[c] !== sample_t'(e)) begin
                    errors++; $display("FAIL sat%0d_ch%0d: got %0d expected %0d", g, c, $signed(out_ch[c]), e);
                end
            end
        end
    endtask

    task automatic test_reset_midgroup();
        int pulses = 0;
        int pulse_at = -1;
        for (int i = 0; i < 3; i++) step(1'b1, mk_win(60, 60), 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_ch !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: out %h valid %b expected 0 / 0", out_ch, out_valid);
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            step(i < 5, (i < 5) ? rand_win() : window_t'('0), 1'b0);
            if (out_valid === 1'b1) begin
                pulses++;
                pulse_at = i;
                for (int c = 0; c < 4; c++) begin
                    checks++;
                    if (out_ch[c] !== sample_t'(exp_out[c])) begin
                        errors++; $display("FAIL post_reset_ch%0d: got %0d expected %0d", c, $signed(out_ch[c]), exp_out[c]);
                    end
                end
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != 5) begin
            errors++; $display("FAIL post_reset_pulses: got %0d at step %0d expected 1 at step 5", pulses, pulse_at);
        end
    endtask

    task automatic test_bubbles();
        int seq [5] = '{10, -20, 30, 127, 5};
        int exp [4] = '{127, 20, 31, 0};
        int early = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, mk_win(seq[i], 0), 1'b0);
            if (out_valid !== 1'b0) early++;
            if (i < 4) begin
                int n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) begin
                    step(1'b0, '0, 1'b0);
                    if (out_valid !== 1'b0) early++;
                end
            end
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL bubble_early: got %0d early pulses expected 0", early);
        end
        step(1'b0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL bubble_pulse: got %b expected 1", out_valid);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_ch[c] !== sample_t'(exp[c])) begin
                errors++; $display("FAIL bubble_ch%0d: got %0d expected %0d", c, $signed(out_ch[c]), exp[c]);
            end
        end
    endtask

    task automatic test_clr();
        int early = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk_win(100, 0), 1'b0);
            if (out_valid !== 1'b0) early++;
        end
        step(1'b1, mk_win(7, 0), 1'b1);
        if (out_valid !== 1'b0) early++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, mk_win(9, 0), 1'b0);
            if (out_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL clr_early: got %0d early pulses expected 0", early);
        end
        step(1'b0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_ch[0] !== sample_t'(9)) begin
            errors++; $display("FAIL clr_result: valid %b ch0 %0d expected 1 / 9", out_valid, $signed(out_ch[0]));
        end
    endtask

    task automatic test_back_to_back();
        int     idx [$];
        chvec_t cap [$];
        int     exp1 [4] = '{50, 0, 62, 49};
        for (int i = 0; i < 11; i++) begin
            step(i < 10, (i < 5) ? mk_win(50, 50) : window_t'('0), 1'b0);
            if (out_valid === 1'b1) begin
                idx.push_back(i);
                cap.push_back(out_ch);
            end
        end
        checks++;
        if (idx.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d pulses expected 2", idx.size());
        end else begin
            checks++;
            if (idx[0] != 5 || idx[1] - idx[0] != 5) begin
                errors++; $display("FAIL b2b_spacing: got steps %0d,%0d expected 5,10", idx[0], idx[1]);
            end
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (cap[0][c] !== sample_t'(exp1[c])) begin
                    errors++; $display("FAIL b2b_p1_ch%0d: got %0d expected %0d", c, $signed(cap[0][c]), exp1[c]);
                end
            end
            checks++;
            if (cap[1] !== '0) begin
                errors++; $display("FAIL b2b_p2_leak: got %h expected 0", cap[1]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, rand_win(), $urandom_range(0, 31) == 0);
            checks++;
            if (out_valid !== exp_valid) begin
                errors++; $display("FAIL rand_valid: cycle %0d got %b expected %b", i, out_valid, exp_valid);
            end
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (out_ch[c] !== sample_t'(exp_out[c])) begin
                    errors++; $display("FAIL rand_ch%0d: cycle %0d got %0d expected %0d", c, i, $signed(out_ch[c]), exp_out[c]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_reset_midgroup();
        test_bubbles();
        test_clr();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_relu_pool_layer1.md
Name: conv_relu_pool_layer1

Overview:
- Streaming first-layer datapath of the 1-D CNN ECG classifier.
- Each accepted 5-sample window is convolved with 4 fixed kernels, passed through ReLU, and max-pooled over 5 consecutive results per channel (pool stride 5).
- Sits between the layer-1 controller, which feeds sliding windows from sample memory, and the layer-2 input buffer.
- A full 2504-sample record yields 2500 conv results and 500 pooled outputs per channel.

Parameters:
- DATA_W, 8, sample/weight/output width (signed two's complement).
- KERNEL, 5, taps per kernel (window length).
- N_CH, 4, output channels (filters).
- POOL, 5, conv results per pooled output.
- FRAC, 6, fractional bits of weights (Q1.6; 64 = 1.0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous group restart: empties pool group and in-flight conv result.
- in_valid  in  1  window present this cycle.
- in_win  in  KERNEL x DATA_W signed  window; element 0 = oldest sample.
- out_ch  out  N_CH x DATA_W  pooled ReLU outputs, 0..127.
- out_valid  out  1  one-cycle pulse, out_ch valid.

Behaviour:
- Reset (rst low, asynchronous): conv regs, conv_valid, running max, pool counter (0..4), out_ch and out_valid all go to 0. They stay 0 until rst is released.
- Conv stage (registered, 1 cycle): on a clk edge with in_valid=1, for each channel c:
  - acc = sum_k in_win[k]*W[c][k], signed, at least 19 bits.
  - y = (acc >>> FRAC) + B[c]. The shift is arithmetic (floor). B is an integer in output LSBs.
  - Saturate y to [-128,127] and register it; conv_valid <= 1.
- Conv stage with in_valid=0: conv_valid <= 0 and the conv regs hold.
- ReLU: combinational on the conv regs; r = (y<0) ? 0 : y.
- Pool stage, on an edge with conv_valid=1:
  - count<4: running max m[c] <= (count==0) ? r[c] : max(m[c], r[c]); count++.
  - count==4: out_ch[c] <= max(m[c], r[c]); out_valid <= 1; count <= 0.
- out_valid is 0 on every other edge. out_ch holds its last value between pulses.
- Latency: the 5th window of a group is accepted at edge t; out_valid is high in the cycle after edge t+1.
- Gaps in in_valid are allowed anywhere; group state holds across them.
- Back-to-back windows sustain 1 window/cycle, giving one output per 5 cycles. The running max never carries into the next group.
- clr=1 at an edge:
  - count <= 0, m <= 0, out_valid <= 0; the pending conv result is discarded.
  - If in_valid=1 in the same cycle, that window is registered and counts as the first of the new group.
- rst low mid-group aborts the group with no partial output.
- Default coefficient set (package constants; trained values drop in later with the same format):
  - ch0: W = [64,0,0,0,0], B = 0 (identity of oldest sample).
  - ch1: W = [-64,0,0,0,0], B = 0 (negated oldest sample).
  - ch2: W = [16,16,16,16,16], B = 0 (sum/4).
  - ch3: W = [0,0,64,0,0], B = -1 (centre sample minus 1).

Decomposition:
- Package cnn_l1_pkg holds DATA_W/KERNEL/N_CH/POOL/FRAC, the signed sample typedef, the window and channel-vector typedefs, W[N_CH][KERNEL] and B[N_CH], and a saturate-to-int8 function.
- One natural sub-module: conv_mac_ch, one channel's 5-tap MAC plus shift/bias/saturate. It is instantiated N_CH times.
- ReLU and pooling stay inline.

Test Plan:
- Reset: run 3 windows, pull rst low asynchronously -> out_ch = 0 and out_valid = 0 immediately. After release, 5 windows produce exactly one out_valid.
- Basic group: oldest samples 10,-20,30,127,5, all other samples 0, 5 consecutive cycles -> single pulse 2 cycles after the 5th window, out_ch = {127,20,31,0}.
- Saturation: 5 windows of all 127 -> ch2 = 127 (158 clipped), ch0 = 127. Then 5 windows of all -128 -> ch1 = 127 (128 clipped), ch0 = 0, ch2 = 0.
- Bubbles: same stimulus as the basic group with in_valid low 1-3 cycles between windows -> identical out_ch; out_valid only after the 5th valid window.
- clr: 3 windows of oldest sample 100, then clr with a window of oldest 7, then 4 windows of oldest 9 -> one pulse with ch0 = 9, not 100.
- Back-to-back: 10 consecutive windows, first group all 50s, second all 0 -> pulses exactly 5 cycles apart.
  - Pulse 1: ch0 = 50, ch2 = 62, ch3 = 49.
  - Pulse 2: all channels 0 (no max leakage).
